// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults and derived totals, plus a window-compare
// helper used by the sync generators and neighbouring blocks.
package vga_pkg;

    localparam int CNT_W      = 10;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int H_TOTAL      = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL      = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START = H_VIS_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int V_SYNC_START = V_VIS_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    function automatic logic in_window(input logic [CNT_W-1:0] val, input int lo, input int hi);
        return (int'(val) >= lo) && (int'(val) <= hi);
    endfunction

endpackage

// File: rtl/sync_counter.sv
// Wrap counter with enable, terminal-count flag and a registered active-low
// sync pulse that is computed from the next count so it stays aligned with cnt.
module sync_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int SYNC_START = H_SYNC_START,
    parameter int SYNC_END   = H_SYNC_END
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             tc,
    output logic             sync_n
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_n_q, sync_n_d;

    // Next count and the sync level that goes with it
    always_comb begin
        tc       = (cnt_q == LAST);
        cnt_d    = cnt_q;
        if (en) begin
            if (tc) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
        sync_n_d = ~in_window(cnt_d, SYNC_START, SYNC_END);
    end

    // Count and sync registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= {CNT_W{1'b0}};
            sync_n_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;
    assign sync_n  = sync_n_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: half-rate pixel enable, h/v counters, syncs, visible-area
// enable, frame-start strobe and a sticky vertical-blank interrupt.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblank_ack,
    output logic [31:0] row,
    output logic [31:0] colu,
    output logic        col_en,
    output logic        hsync,
    output logic        vsync,
    output logic        pix_en,
    output logic        frame_start,
    output logic        vblank_irq
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
    logic             h_tc, v_tc, hsync_n, vsync_n, v_en;
    logic             pix_en_q, pix_en_d;
    logic             col_en_q, col_en_d;
    logic             frame_start_q, frame_start_d;
    logic             vblank_irq_q, vblank_irq_d;
    logic             vblank_set;

    assign v_en = pix_en_q & h_tc;

    sync_counter #(
        .TOTAL      (H_TOT),
        .SYNC_START (H_VIS + H_FP),
        .SYNC_END   (H_VIS + H_FP + H_SYNC - 1)
    ) u_h (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pix_en_q),
        .cnt     (h_cnt),
        .cnt_nxt (h_nxt),
        .tc      (h_tc),
        .sync_n  (hsync_n)
    );

    sync_counter #(
        .TOTAL      (V_TOT),
        .SYNC_START (V_VIS + V_FP),
        .SYNC_END   (V_VIS + V_FP + V_SYNC - 1)
    ) u_v (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (v_en),
        .cnt     (v_cnt),
        .cnt_nxt (v_nxt),
        .tc      (v_tc),
        .sync_n  (vsync_n)
    );

    // Flag next-state; set beats ack so a coincident ack cannot lose an interrupt
    always_comb begin
        pix_en_d      = ~pix_en_q;
        col_en_d      = (int'(h_nxt) < H_VIS) && (int'(v_nxt) < V_VIS);
        frame_start_d = pix_en_q & h_tc & v_tc;
        vblank_set    = pix_en_q & h_tc & (v_cnt == CNT_W'(V_VIS - 1));
        if (vblank_set) begin
            vblank_irq_d = 1'b1;
        end else if (vblank_ack) begin
            vblank_irq_d = 1'b0;
        end else begin
            vblank_irq_d = vblank_irq_q;
        end
    end

    // Output and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en_q      <= 1'b0;
            col_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_irq_q  <= 1'b0;
        end else begin
            pix_en_q      <= pix_en_d;
            col_en_q      <= col_en_d;
            frame_start_q <= frame_start_d;
            vblank_irq_q  <= vblank_irq_d;
        end
    end

    assign row         = {{(32-CNT_W){1'b0}}, h_cnt};
    assign colu        = {{(32-CNT_W){1'b0}}, v_cnt};
    assign col_en      = col_en_q;
    assign hsync       = hsync_n;
    assign vsync       = vsync_n;
    assign pix_en      = pix_en_q;
    assign frame_start = frame_start_q;
    assign vblank_irq  = vblank_irq_q;

endmodule
